// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: takes a parallel word over valid/ready and sends it
// MSB-first on A, one bit per clock, followed by a fixed idle gap.
module seq_pattern_tx #(
   parameter int   WIDTH      = 8,
   parameter int   GAP        = 2,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             A,
   output logic             frame,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   // Handshake: a word transfers on a rising edge where din_valid && din_ready;
   // din_ready depends on state only, never on din_valid.
   state_t           state, state_nx;
   logic [WIDTH-1:0] sreg, sreg_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [3:0]       gcnt, gcnt_nx;
   logic             a_nx, frame_nx, done_nx;

   assign din_ready = (state == S_IDLE);

   always_comb begin
      state_nx = state;
      sreg_nx  = sreg;
      cnt_nx   = cnt;
      gcnt_nx  = gcnt;
      a_nx     = IDLE_LEVEL;
      frame_nx = 1'b0;
      case (state)
         S_IDLE: begin
            if (din_valid) begin
               sreg_nx  = din;
               cnt_nx   = '0;
               gcnt_nx  = '0;
               state_nx = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // The state register runs one cycle ahead of the registered A/frame.
            a_nx     = sreg[WIDTH-1];
            frame_nx = 1'b1;
            sreg_nx  = {sreg[WIDTH-2:0], 1'b0};
            cnt_nx   = cnt + CW'(1);
            if (cnt == LAST_BIT)
               state_nx = (GAP > 0) ? S_GAP : S_IDLE;
         end
         S_GAP: begin
            gcnt_nx = gcnt + 4'd1;
            if (gcnt == GAP_LAST) begin
               gcnt_nx  = '0;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
      // A frame ends exactly when frame falls, so done can never repeat for one word.
      done_nx = frame & ~frame_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         sreg  <= '0;
         cnt   <= '0;
         gcnt  <= '0;
         A     <= IDLE_LEVEL;
         frame <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         sreg  <= sreg_nx;
         cnt   <= cnt_nx;
         gcnt  <= gcnt_nx;
         A     <= a_nx;
         frame <= frame_nx;
         done  <= done_nx;
      end
   end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter for the sequence-circuit family. It accepts a parallel word over a valid/ready handshake and drives it MSB-first, one bit per clock, on the single-bit line `A` that the sequence detectors and state-machine circuits consume. A frame qualifier, a configurable inter-frame gap and a completion pulse let a bench or upstream controller stream back-to-back patterns into a detector under test.

## Interface
- `WIDTH`, default 8: bits per frame; legal range 2..32.
- `GAP`, default 2: idle cycles forced after each frame; legal range 0..15.
- `IDLE_LEVEL`, default 1'b1: value driven on `A` whenever no frame bit is being sent.

Ports:
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  asynchronous, active-high reset.
- `din`  input  WIDTH  pattern word; `din[WIDTH-1]` is sent first.
- `din_valid`  input  1  `din` is valid.
- `din_ready`  output  1  block can accept a word this cycle.
- `A`  output  1  serial pattern bit, registered.
- `frame`  output  1  high while `A` carries a pattern bit, registered.
- `done`  output  1  one-cycle pulse after the last bit of a frame, registered.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE:
  - `din_ready`=1, decoded from state.
  - On a rising edge with `din_valid`=1, load `din` into the shift register, clear the bit counter and go to SHIFT.
- SHIFT:
  - `A` = shift register MSB and `frame`=1 for exactly WIDTH cycles.
  - The register shifts left once per cycle; the counter increments.
  - After the cycle showing bit 0, go to GAP when GAP>0, otherwise to IDLE.
  - `din_valid` is ignored and `din_ready`=0.
- GAP:
  - `A`=IDLE_LEVEL, `frame`=0, `din_ready`=0.
  - Lasts exactly GAP cycles, then goes to IDLE.
- `done`:
  - Pulses high for one cycle, the cycle immediately after the last frame bit.
  - That cycle is the first GAP cycle, or the first IDLE cycle when GAP=0.
  - It never pulses twice for one frame.
- Counter width is clog2(WIDTH)+1. The gap counter is 4 bits. No wrap occurs within legal parameter ranges.
- A word presented while `din_ready`=0 is neither captured nor lost: the upstream must hold it until a handshake occurs.

## Timing
- Reset values: state=IDLE, `A`=IDLE_LEVEL, `frame`=0, `done`=0, shift register=0, counters=0, `din_ready`=1 (decoded). No transfer is accepted while `rst`=1.
- Reset asserted mid-frame or mid-gap: outputs take their reset values immediately (asynchronously). The partial frame is discarded. There is no `done` for it.
- Latency: handshake on edge N; first bit (`din[WIDTH-1]`) on `A` with `frame`=1 from edge N+1; last bit from edge N+WIDTH; `done`=1 from edge N+WIDTH+1.
- Frame-to-frame spacing:
  - With `din_valid` held high, the next handshake occurs at edge N+WIDTH+GAP+1.
  - The minimum period is therefore WIDTH+GAP+1 cycles. GAP=0 still yields one IDLE cycle, with `A`=IDLE_LEVEL and `frame`=0.
- `din` and `din_valid` are sampled only on the handshake edge. Changes to `din` during SHIFT have no effect.
- `A` and `frame` change only on rising clock edges, so the bit is stable for the consumer's next sampling edge.

## Test plan
- Reset release, then `din`=8'b1011_0010 with `din_valid`=1 for one cycle (WIDTH=8, GAP=2, IDLE_LEVEL=1):
  - `A` = 1,0,1,1,0,0,1,0 across 8 cycles with `frame`=1.
  - `done` pulses on cycle 9.
  - `A`=1 and `din_ready`=0 for 2 gap cycles, then `din_ready`=1.
- `din_valid` held high with words 8'hA5 then 8'h3C:
  - Second frame's first bit (0) appears exactly 11 cycles after the first frame's first bit.
  - No bit is dropped or duplicated.
- GAP=0, `din_valid` held high:
  - Exactly one IDLE cycle (`frame`=0, `A`=1) between frames.
  - `done` coincides with that IDLE cycle.
- `rst` pulsed high during bit 4 of a frame:
  - `A`=1, `frame`=0 and `done`=0 immediately.
  - After release, the state is IDLE, no `done` occurs, and a new word transmits correctly.
- `din` changed mid-frame while `din_valid`=1:
  - Transmitted bits match the word captured at the handshake.
  - The new word is taken only when `din_ready` returns to 1.
- IDLE_LEVEL=0, WIDTH=4, drive `seq_circuit` `A` input with pattern 4'b1100:
  - Serial stream is 1,1,0,0 followed by 0s.
  - Detector `Y` response matches its reference model cycle-for-cycle.
